// File: rtl/key_frame_loader_if.sv
// Serial key-frame handshake between the secure key store and the loader.
// Carries sdi/sdi_valid from the store and sdi_ready back from the loader.
interface key_frame_loader_if;
    logic sdi;
    logic sdi_valid;
    logic sdi_ready;

    modport master (
        output sdi,
        output sdi_valid,
        input  sdi_ready
    );

    modport slave (
        input  sdi,
        input  sdi_valid,
        output sdi_ready
    );
endinterface

// File: rtl/key_frame_loader.sv
// Key-provisioning front end: deframes a serial A5-headed key frame,
// checks CRC-8 (poly 0x07) over the key, and presents a verified key.
// Ports: CK clock, RST async active-high reset, s serial handshake
// (slave), key_out/key_valid verified key, load_err CRC-fail pulse,
// fail_cnt saturating reject count, lockout sticky refusal flag.
module key_frame_loader #(
    parameter int          KEY_W    = 36,
    parameter logic [7:0]  HDR      = 8'hA5,
    parameter int          MAX_FAIL = 3
) (
    input  logic             CK,
    input  logic             RST,
    key_frame_loader_if.slave s,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             load_err,
    output logic [1:0]       fail_cnt,
    output logic             lockout
);

    localparam int CW = $clog2(KEY_W);

    typedef enum logic [2:0] {
        SYNC,
        KEY,
        RXCRC,
        CHECK,
        LOCK
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_win;
    logic [CW-1:0]    r_cnt;
    logic [7:0]       r_crc;
    logic [7:0]       r_rxcrc;
    logic [KEY_W-1:0] r_stage;

    logic             w_rdy;
    logic             w_take;
    logic [7:0]       w_win;
    logic             w_fb;
    logic [7:0]       w_crc;
    logic             w_match;
    logic [1:0]       w_fail_inc;
    logic             w_to_lock;

    assign w_take     = s.sdi_valid & s.sdi_ready;
    assign w_win      = {r_win[6:0], s.sdi};
    assign w_fb       = r_crc[7] ^ s.sdi;
    assign w_crc      = {r_crc[6:0], 1'b0} ^ (w_fb ? 8'h07 : 8'h00);
    assign w_match    = (r_rxcrc == r_crc);
    assign w_fail_inc = (fail_cnt == 2'(MAX_FAIL)) ? fail_cnt
                                                   : fail_cnt + 2'd1;
    assign w_to_lock  = (w_fail_inc == 2'(MAX_FAIL));

    // Ready is forced low while reset is held, not just after the edge.
    assign s.sdi_ready = w_rdy & ~RST;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_rdy    = 1'b0;
        load_err = 1'b0;
        lockout  = 1'b0;
        unique case (r_state)
            SYNC: begin
                w_rdy = 1'b1;
                if (w_take && w_win == HDR) w_next = KEY;
            end
            KEY: begin
                w_rdy = 1'b1;
                if (w_take && r_cnt == CW'(KEY_W - 1)) w_next = RXCRC;
            end
            RXCRC: begin
                w_rdy = 1'b1;
                if (w_take && r_cnt == CW'(7)) w_next = CHECK;
            end
            CHECK: begin
                if (w_match) begin
                    w_next = SYNC;
                end else begin
                    load_err = 1'b1;
                    w_next   = w_to_lock ? LOCK : SYNC;
                end
            end
            LOCK: begin
                lockout = 1'b1;
            end
            default: w_next = SYNC;
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_win     <= '0;
            r_cnt     <= '0;
            r_crc     <= '0;
            r_rxcrc   <= '0;
            r_stage   <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            fail_cnt  <= '0;
        end else begin
            unique case (r_state)
                SYNC: begin
                    if (w_take) begin
                        r_win <= w_win;
                        if (w_win == HDR) begin
                            r_cnt <= '0;
                            r_crc <= '0;
                        end
                    end
                end
                KEY: begin
                    if (w_take) begin
                        r_stage <= {r_stage[KEY_W-2:0], s.sdi};
                        r_crc   <= w_crc;
                        r_cnt   <= (r_cnt == CW'(KEY_W - 1)) ? '0
                                                             : r_cnt + 1'b1;
                    end
                end
                RXCRC: begin
                    if (w_take) begin
                        r_rxcrc <= {r_rxcrc[6:0], s.sdi};
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    // Fresh header search for the next frame.
                    r_win <= '0;
                    if (w_match) begin
                        key_out   <= r_stage;
                        key_valid <= 1'b1;
                        fail_cnt  <= '0;
                    end else begin
                        fail_cnt <= w_fail_inc;
                        if (w_to_lock) begin
                            key_out   <= '0;
                            key_valid <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_frame_loader.sv
// Directed self-checking bench for key_frame_loader.
// Drives frames on the negative edge and samples outputs there too.
module tb_key_frame_loader;

    logic        CK = 1'b0;
    logic        RST;
    logic [35:0] key_out;
    logic        key_valid;
    logic        load_err;
    logic [1:0]  fail_cnt;
    logic        lockout;

    int n_cmp = 0;
    int n_bad = 0;
    int n_err = 0;
    int e0;

    key_frame_loader_if bus ();

    key_frame_loader dut (
        .CK        (CK),
        .RST       (RST),
        .s         (bus),
        .key_out   (key_out),
        .key_valid (key_valid),
        .load_err  (load_err),
        .fail_cnt  (fail_cnt),
        .lockout   (lockout)
    );

    always #5 CK = ~CK;

    always @(negedge CK) if (load_err) n_err++;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge CK);
        bus.sdi       = b;
        bus.sdi_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CK);
            bus.sdi_valid = 1'b0;
            bus.sdi       = 1'b1;
        end
    endtask

    // Leaves the caller at the negedge of the CHECK cycle.
    task automatic send_frame(input logic [35:0] key, input logic [7:0] crc,
                              input int stall_at, input int stall_len);
        logic [51:0] f;
        f = {8'hA5, key, crc};
        for (int i = 51; i >= 0; i--) begin
            if (51 - i == stall_at) idle(stall_len);
            send_bit(f[i]);
        end
        @(negedge CK);
        bus.sdi_valid = 1'b0;
    endtask

    task automatic do_reset();
        RST           = 1'b1;
        bus.sdi       = 1'b0;
        bus.sdi_valid = 1'b0;
        repeat (2) @(negedge CK);
        chk("rst_key", 64'(key_out), 64'h0);
        chk("rst_kv", 64'(key_valid), 64'h0);
        chk("rst_err", 64'(load_err), 64'h0);
        chk("rst_fail", 64'(fail_cnt), 64'h0);
        chk("rst_lock", 64'(lockout), 64'h0);
        chk("rst_rdy", 64'(bus.sdi_ready), 64'h0);
        RST = 1'b0;
        #1;
        chk("rdy_after_rst", 64'(bus.sdi_ready), 64'h1);
    endtask

    initial begin
        logic [51:0] f;

        do_reset();

        // Good frame: key 1, CRC 07.
        e0 = n_err;
        send_frame(36'h000000001, 8'h07, -1, 0);
        @(negedge CK);
        chk("t1_key", 64'(key_out), 64'h1);
        chk("t1_kv", 64'(key_valid), 64'h1);
        chk("t1_noerr", 64'(n_err - e0), 64'h0);
        chk("t1_fail", 64'(fail_cnt), 64'h0);

        // Zero key with a 5-cycle stall after 12 key bits.
        send_frame(36'h000000000, 8'h00, 20, 5);
        @(negedge CK);
        chk("t2_key", 64'(key_out), 64'h0);
        chk("t2_kv", 64'(key_valid), 64'h1);

        // Reload key 1, then a bad-CRC frame.
        send_frame(36'h000000001, 8'h07, -1, 0);
        @(negedge CK);
        chk("t3_key0", 64'(key_out), 64'h1);
        e0 = n_err;
        send_frame(36'hFFFFFFFFF, 8'h00, -1, 0);
        chk("t3_err_on", 64'(load_err), 64'h1);
        @(negedge CK);
        chk("t3_err_off", 64'(load_err), 64'h0);
        chk("t3_err_cnt", 64'(n_err - e0), 64'h1);
        chk("t3_key", 64'(key_out), 64'h1);
        chk("t3_kv", 64'(key_valid), 64'h1);
        chk("t3_fail", 64'(fail_cnt), 64'h1);
        send_frame(36'h000000000, 8'h00, -1, 0);
        @(negedge CK);
        chk("t3_fail_clr", 64'(fail_cnt), 64'h0);
        chk("t3_key2", 64'(key_out), 64'h0);

        // Three bad frames lock the loader out.
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            send_frame(36'hFFFFFFFFF, 8'h00, -1, 0);
            @(negedge CK);
            chk($sformatf("t4_fail%0d", k), 64'(fail_cnt), 64'(k));
        end
        chk("t4_lock", 64'(lockout), 64'h1);
        chk("t4_kv", 64'(key_valid), 64'h0);
        chk("t4_key", 64'(key_out), 64'h0);
        chk("t4_rdy", 64'(bus.sdi_ready), 64'h0);
        send_frame(36'h000000001, 8'h07, -1, 0);
        @(negedge CK);
        chk("t4_ign_key", 64'(key_out), 64'h0);
        chk("t4_ign_kv", 64'(key_valid), 64'h0);
        chk("t4_ign_lock", 64'(lockout), 64'h1);
        chk("t4_ign_fail", 64'(fail_cnt), 64'h3);

        // Garbage bits before the header.
        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_frame(36'h000000001, 8'h07, -1, 0);
        @(negedge CK);
        chk("t5_key", 64'(key_out), 64'h1);
        chk("t5_kv", 64'(key_valid), 64'h1);

        // Asynchronous reset after 20 key bits.
        f = {8'hA5, 36'h000000001, 8'h07};
        for (int i = 51; i >= 24; i--) send_bit(f[i]);
        @(negedge CK);
        bus.sdi_valid = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk("t6_key", 64'(key_out), 64'h0);
        chk("t6_kv", 64'(key_valid), 64'h0);
        chk("t6_rdy", 64'(bus.sdi_ready), 64'h0);
        chk("t6_lock", 64'(lockout), 64'h0);
        chk("t6_fail", 64'(fail_cnt), 64'h0);
        @(negedge CK);
        RST = 1'b0;
        send_frame(36'h000000001, 8'h07, -1, 0);
        @(negedge CK);
        chk("t6_reload_key", 64'(key_out), 64'h1);
        chk("t6_reload_kv", 64'(key_valid), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
